line_fetcher: RTL and testbench
===============================

LINE_FETCHER -- requirements
Module: line_fetcher

Interface
REQ-001 clk_12_5875  in  1  pixel clock; rising edge only.
REQ-002 rst  in  1  synchronous, active-high reset.
REQ-003 hcounter_i  in  10  horizontal count from timing generator; 0..399, visible 0..319.
REQ-004 vcounter_i  in  10  vertical count from timing generator; 0..524, visible 0..479.
REQ-005 visible_i  in  1  high while hcounter_i<320 and vcounter_i<480.
REQ-006 hsync_i, vsync_i  in  1 each  active-low syncs from timing generator.
REQ-007 vram_addr_o  out  16  VRAM byte address = {game_line[7:0], game_x[7:0]}.
REQ-008 vram_rd_o  out  1  read strobe; data returned on vram_data_i exactly one cycle later.
REQ-009 vram_data_i  in  8  pixel byte; bits [5:0] = RRGGBB, bits [7:6] ignored.
REQ-010 r_o, g_o, b_o  out  2 each  pixel colour, aligned with hsync_o/vsync_o.
REQ-011 hsync_o, vsync_o  out  1 each  hsync_i/vsync_i delayed 2 cycles.

Function
REQ-012 Game frame SHALL be 256x240 pixels; each game line is shown on two consecutive VGA lines (game_line = vcounter>>1); game_x = hcounter-32 for hcounter 32..287.
REQ-013 Outside hcounter 32..287, or when visible_i=0, pixel output SHALL be border colour 0.
REQ-014 Two 256x6 line buffers SHALL exist: front (display read), back (fetch write).
REQ-015 FSM states: IDLE, FETCH, DONE.
REQ-016 IDLE->FETCH when hcounter_i==0 and (vcounter_i odd and <=477, or vcounter_i==524); target game line g = (vcounter_i+1)>>1, wrapping 525->0 so line 524 fetches g=0.
REQ-017 FETCH: vram_rd_o=1 for 256 consecutive cycles, game_x 0..255; each returned byte written to back buffer at address game_x one cycle later.
REQ-018 FETCH->DONE after last write (cycle 257 of fetch); DONE->IDLE at hcounter_i==399 with front/back swap in the same cycle.
REQ-019 vram_rd_o SHALL be 0 in IDLE and DONE; no fetch SHALL start on even VGA lines 0..478 or lines 479..523.
REQ-020 Display read latency: buffer read registered (1 cycle) + colour register (1 cycle) = 2 cycles; syncs delayed identically.
REQ-021 Swap SHALL occur only from DONE; an incomplete fetch never swaps.

Reset
REQ-022 On rst: FSM=IDLE, front select=0, vram_rd_o=0, vram_addr_o=0, r_o/g_o/b_o=0, hsync_o=vsync_o=1, sync delay stages=1.
REQ-023 rst during FETCH SHALL abort the fetch with no swap; buffer contents are not cleared.
REQ-024 After rst release, first fetch SHALL wait for the next qualifying hcounter_i==0 (REQ-016).

Configuration
REQ-025 Macro SCANLINE_DIM_EN: when defined, pixels on odd VGA lines SHALL output each 2-bit channel shifted right by 1; when undefined, odd and even lines are identical.

Structure
REQ-026 gpu_pkg SHALL hold GAME_W=256, GAME_H=240, H_OFFSET=32, the rgb6_t typedef (three 2-bit fields), and the FSM state enum.
REQ-027 Line buffers SHALL be one sub-module line_buffer_ram (256x6, one write port, one synchronous read port), instantiated twice.

Verification
REQ-028 vcounter_i=1, hcounter_i=0 -> vram_rd_o high 256 cycles, vram_addr_o 0x0100..0x01FF, swap at hcounter_i=399.
REQ-029 VRAM byte at 0x0105 = 0x2A; VGA lines 2 and 3, hcounter_i=37 -> rgb = (2,2,2) two cycles later on both lines (odd line (1,1,1) with SCANLINE_DIM_EN).
REQ-030 vcounter_i=524, hcounter_i=0 -> fetch addresses 0x0000..0x00FF; lines 0/1 display game line 0.
REQ-031 vcounter_i=479 or any even line, hcounter_i=0 -> vram_rd_o stays 0 entire line.
REQ-032 rst asserted at fetch cycle 100 -> vram_rd_o=0 next cycle, no swap, outputs at reset values, syncs =1.
REQ-033 hcounter_i=20 or 300 with visible_i=1 -> rgb=0; hsync_o equals hsync_i from two cycles earlier.

Source files
------------

// File: rtl/line_fetcher_pkg.sv
// Shared types and constants for the scan-doubling line fetcher.
package gpu_pkg;

    localparam int GAME_W   = 256;
    localparam int GAME_H   = 240;
    localparam int H_OFFSET = 32;

    localparam logic [9:0] H_LAST      = 10'd399;
    localparam logic [9:0] V_LAST      = 10'd524;
    localparam logic [9:0] V_FETCH_MAX = 10'd477;

    typedef struct packed {
        logic [1:0] r;
        logic [1:0] g;
        logic [1:0] b;
    } rgb6_t;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DONE
    } fetch_state_e;

    function automatic rgb6_t dim(input rgb6_t c);
        return rgb6_t'({1'b0, c.r[1], 1'b0, c.g[1], 1'b0, c.b[1]});
    endfunction

endpackage

// File: rtl/line_fetcher_if.sv
// Timing-in, VRAM read bus and pixel-out bundle for line_fetcher.
interface line_fetcher_if;

    logic [9:0]  hcounter_i;
    logic [9:0]  vcounter_i;
    logic        visible_i;
    logic        hsync_i;
    logic        vsync_i;
    logic [15:0] vram_addr_o;
    logic        vram_rd_o;
    logic [7:0]  vram_data_i;
    logic [1:0]  r_o;
    logic [1:0]  g_o;
    logic [1:0]  b_o;
    logic        hsync_o;
    logic        vsync_o;

    modport slave (
        input  hcounter_i, vcounter_i, visible_i, hsync_i, vsync_i,
        input  vram_data_i,
        output vram_addr_o, vram_rd_o,
        output r_o, g_o, b_o, hsync_o, vsync_o
    );

    modport master (
        output hcounter_i, vcounter_i, visible_i, hsync_i, vsync_i,
        output vram_data_i,
        input  vram_addr_o, vram_rd_o,
        input  r_o, g_o, b_o, hsync_o, vsync_o
    );

endinterface

// File: rtl/line_fetcher_line_buffer_ram.sv
// 256x6 line buffer: one write port, one registered read port.
module line_buffer_ram
    import gpu_pkg::*;
(
    input  logic       clk_12_5875,
    input  logic       we_i,
    input  logic [7:0] waddr_i,
    input  rgb6_t      wdata_i,
    input  logic [7:0] raddr_i,
    output rgb6_t      rdata_o
);

    rgb6_t mem [GAME_W];
    rgb6_t rdata_q;

    always_ff @(posedge clk_12_5875) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
        rdata_q <= mem[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/line_fetcher.sv
// Fetches one game line per VGA line pair into a back buffer and scans the
// front buffer out. Optional odd-line dimming with SCANLINE_DIM_EN.
module line_fetcher
    import gpu_pkg::*;
(
    input  logic          clk_12_5875,
    input  logic          rst,
    line_fetcher_if.slave bus
);

    fetch_state_e state_q, state_d;
    logic [8:0]   cnt_q, cnt_d;
    logic [7:0]   line_q, line_d;
    logic         front_q, front_d;

    logic         qualify;
    logic         rd;
    logic         wr_q;
    logic [7:0]   waddr_q;
    rgb6_t        wdata;
    logic         unused_data;

    logic         in_win;
    logic [7:0]   raddr;
    rgb6_t        rdata0, rdata1;
    logic         in_q, sel_q, hs1_q, vs1_q;
    rgb6_t        pix_q, pix_d;
    logic         hs2_q, vs2_q;

    assign qualify = (bus.hcounter_i == '0)
                   && ((bus.vcounter_i[0] && bus.vcounter_i <= V_FETCH_MAX)
                       || bus.vcounter_i == V_LAST);

    always_ff @(posedge clk_12_5875) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            line_q  <= '0;
            front_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            line_q  <= line_d;
            front_q <= front_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        line_d  = line_q;
        front_d = front_q;
        unique case (state_q)
            IDLE: begin
                if (qualify) begin
                    state_d = FETCH;
                    cnt_d   = '0;
                    // odd line v fetches (v+1)/2; the last line wraps to 0
                    line_d  = (bus.vcounter_i == V_LAST) ? 8'd0
                            : bus.vcounter_i[8:1] + 8'd1;
                end
            end
            FETCH: begin
                if (cnt_q == 9'(GAME_W)) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 9'd1;
                end
            end
            DONE: begin
                if (bus.hcounter_i == H_LAST) begin
                    state_d = IDLE;
                    front_d = ~front_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign rd              = (state_q == FETCH) && !cnt_q[8];
    assign bus.vram_rd_o   = rd;
    assign bus.vram_addr_o = rd ? {line_q, cnt_q[7:0]} : '0;

    always_ff @(posedge clk_12_5875) begin
        if (rst) begin
            wr_q    <= 1'b0;
            waddr_q <= '0;
        end else begin
            wr_q    <= rd;
            waddr_q <= cnt_q[7:0];
        end
    end

    assign wdata       = rgb6_t'(bus.vram_data_i[5:0]);
    assign unused_data = ^bus.vram_data_i[7:6];

    assign in_win = bus.visible_i
                  && bus.hcounter_i >= 10'(H_OFFSET)
                  && bus.hcounter_i <= 10'(H_OFFSET + GAME_W - 1);
    assign raddr  = bus.hcounter_i[7:0] - 8'(H_OFFSET);

    // back buffer is the one not selected by front_q
    line_buffer_ram u_buf0 (
        .clk_12_5875 (clk_12_5875),
        .we_i        (wr_q && front_q),
        .waddr_i     (waddr_q),
        .wdata_i     (wdata),
        .raddr_i     (raddr),
        .rdata_o     (rdata0)
    );

    line_buffer_ram u_buf1 (
        .clk_12_5875 (clk_12_5875),
        .we_i        (wr_q && !front_q),
        .waddr_i     (waddr_q),
        .wdata_i     (wdata),
        .raddr_i     (raddr),
        .rdata_o     (rdata1)
    );

`ifdef SCANLINE_DIM_EN
    logic odd_q;

    always_ff @(posedge clk_12_5875) begin
        if (rst) begin
            odd_q <= 1'b0;
        end else begin
            odd_q <= bus.vcounter_i[0];
        end
    end
`endif

    always_ff @(posedge clk_12_5875) begin
        if (rst) begin
            in_q  <= 1'b0;
            sel_q <= 1'b0;
            hs1_q <= 1'b1;
            vs1_q <= 1'b1;
            pix_q <= '0;
            hs2_q <= 1'b1;
            vs2_q <= 1'b1;
        end else begin
            in_q  <= in_win;
            sel_q <= front_q;
            hs1_q <= bus.hsync_i;
            vs1_q <= bus.vsync_i;
            pix_q <= pix_d;
            hs2_q <= hs1_q;
            vs2_q <= vs1_q;
        end
    end

    always_comb begin
        pix_d = sel_q ? rdata1 : rdata0;
        if (!in_q) begin
            pix_d = '0;
        end
`ifdef SCANLINE_DIM_EN
        if (odd_q) begin
            pix_d = dim(pix_d);
        end
`endif
    end

    assign bus.r_o     = pix_q.r;
    assign bus.g_o     = pix_q.g;
    assign bus.b_o     = pix_q.b;
    assign bus.hsync_o = hs2_q;
    assign bus.vsync_o = vs2_q;

endmodule

// File: tb/tb_line_fetcher.sv
// Scoreboard bench for line_fetcher: stimulus queues expectations, a
// negedge monitor pops and compares fetch-bus and pixel outputs.
module tb_line_fetcher;

    logic clk_12_5875 = 1'b0;
    logic rst = 1'b1;

    line_fetcher_if bus ();

    line_fetcher dut (
        .clk_12_5875 (clk_12_5875),
        .rst         (rst),
        .bus         (bus)
    );

    always #5 clk_12_5875 = ~clk_12_5875;

    typedef struct {
        int         cyc;
        bit         chk_rgb;
        logic [5:0] rgb;
        logic       hs;
        logic       vs;
        bit         chk_bus;
    } pix_exp_t;

    typedef struct {
        int          cyc;
        logic [15:0] addr;
    } bus_exp_t;

    pix_exp_t pq[$];
    bus_exp_t bq[$];

    int       cyc = 0;
    int       checks = 0;
    int       failures = 0;
    int       buf_line[2];
    int       fidx;
    bit       prev_rst;
    pix_exp_t prev_exp;
    bit       finish_req = 0;
    bit       final_done = 0;

    function automatic logic [7:0] vram_byte(input logic [15:0] a);
        logic [7:0] b;
        if (a == 16'h0105) return 8'h2A;
        b = a[7:0] * 8'd7 + a[15:8] + 8'h40;
        return b;
    endfunction

    always @(posedge clk_12_5875) cyc <= cyc + 1;

    always @(posedge clk_12_5875)
        bus.vram_data_i <= (bus.vram_rd_o === 1'b1)
                         ? vram_byte(bus.vram_addr_o) : 8'h00;

    pix_exp_t   pe;
    bus_exp_t   be;
    logic [5:0] got;
    bit         bad;

    always @(negedge clk_12_5875) begin
        if (bq.size() > 0 && bq[0].cyc == cyc) begin
            be = bq.pop_front();
            checks++;
            if (bus.vram_rd_o !== 1'b1 || bus.vram_addr_o !== be.addr) begin
                failures++;
                $display("FAIL fetch cyc=%0d got rd=%b addr=%h exp rd=1 addr=%h",
                         cyc, bus.vram_rd_o, bus.vram_addr_o, be.addr);
            end
        end else if (bus.vram_rd_o === 1'b1) begin
            checks++;
            failures++;
            $display("FAIL fetch_extra cyc=%0d got rd=1 addr=%h exp rd=0",
                     cyc, bus.vram_addr_o);
        end
        if (pq.size() > 0 && pq[0].cyc == cyc) begin
            pe  = pq.pop_front();
            got = {bus.r_o, bus.g_o, bus.b_o};
            bad = (bus.hsync_o !== pe.hs) || (bus.vsync_o !== pe.vs)
                || (pe.chk_rgb && got !== pe.rgb)
                || (pe.chk_bus && (bus.vram_rd_o !== 1'b0
                                   || bus.vram_addr_o !== 16'h0000));
            checks++;
            if (bad) begin
                failures++;
                $display("FAIL pixel cyc=%0d got rgb=%b hs=%b vs=%b rd=%b addr=%h exp rgb=%b(chk=%0d) hs=%b vs=%b",
                         cyc, got, bus.hsync_o, bus.vsync_o, bus.vram_rd_o,
                         bus.vram_addr_o, pe.rgb, pe.chk_rgb, pe.hs, pe.vs);
            end
        end
        if (finish_req && !final_done) begin
            checks++;
            if (pq.size() != 0 || bq.size() != 0) begin
                failures++;
                $display("FAIL drain got pix_left=%0d fetch_left=%0d exp 0 0",
                         pq.size(), bq.size());
            end
            final_done = 1;
        end
    end

    task automatic tick(input logic r, input logic [9:0] h, input logic [9:0] v);
        pix_exp_t   e;
        logic [7:0] px;
        @(posedge clk_12_5875);
        #1;
        rst            = r;
        bus.hcounter_i = h;
        bus.vcounter_i = v;
        bus.visible_i  = (h < 10'd320) && (v < 10'd480);
        bus.hsync_i    = !(h >= 10'd328 && h < 10'd376);
        bus.vsync_i    = (v != 10'd478);
        e     = prev_exp;
        e.cyc = cyc + 1;
        if (r || prev_rst) begin
            e.chk_rgb = 1;
            e.rgb     = '0;
            e.hs      = 1'b1;
            e.vs      = 1'b1;
            e.chk_bus = r;
        end
        pq.push_back(e);
        prev_exp.chk_bus = 0;
        prev_exp.hs      = bus.hsync_i;
        prev_exp.vs      = bus.vsync_i;
        if (!(bus.visible_i && h >= 10'd32 && h <= 10'd287)) begin
            prev_exp.chk_rgb = 1;
            prev_exp.rgb     = '0;
        end else if (buf_line[fidx] < 0) begin
            prev_exp.chk_rgb = 0;
            prev_exp.rgb     = '0;
        end else begin
            px = vram_byte({8'(buf_line[fidx]), 8'(h - 10'd32)});
            prev_exp.chk_rgb = 1;
            prev_exp.rgb     = px[5:0];
`ifdef SCANLINE_DIM_EN
            if (v[0])
                prev_exp.rgb = {1'b0, px[5], 1'b0, px[3], 1'b0, px[1]};
`endif
        end
        prev_rst = r;
        if (r) fidx = 0;
    endtask

    task automatic run_line(input logic [9:0] v, input int abort_h);
        bit         fetch;
        logic [7:0] g;
        int         nx;
        bus_exp_t   b;
        fetch = (v[0] && v <= 10'd477) || v == 10'd524;
        g     = (v == 10'd524) ? 8'd0 : 8'((int'(v) + 1) / 2);
        for (int h = 0; h < 400; h++) begin
            tick(abort_h >= 0 && h >= abort_h && h < abort_h + 3, 10'(h), v);
            if (h == 0 && fetch) begin
                nx = (abort_h >= 0) ? abort_h : 256;
                buf_line[fidx ^ 1] = -1;
                for (int x = 0; x < nx; x++) begin
                    b.cyc  = cyc + 1 + x;
                    b.addr = {g, 8'(x)};
                    bq.push_back(b);
                end
            end
        end
        if (fetch && abort_h < 0) begin
            buf_line[fidx ^ 1] = int'(g);
            fidx = fidx ^ 1;
        end
    endtask

    initial begin
        buf_line[0]     = -1;
        buf_line[1]     = -1;
        fidx            = 0;
        prev_rst        = 1;
        prev_exp        = '{default: 0};
        bus.hcounter_i  = '0;
        bus.vcounter_i  = 10'd523;
        bus.visible_i   = 1'b0;
        bus.hsync_i     = 1'b1;
        bus.vsync_i     = 1'b1;
        for (int h = 394; h < 400; h++) tick(h < 397, 10'(h), 10'd523);
        run_line(10'd524, -1);
        run_line(10'd0, -1);
        run_line(10'd1, -1);
        run_line(10'd2, -1);
        run_line(10'd3, -1);
        run_line(10'd4, -1);
        run_line(10'd478, -1);
        run_line(10'd479, -1);
        run_line(10'd5, 100);
        run_line(10'd6, -1);
        run_line(10'd7, -1);
        run_line(10'd8, -1);
        tick(1'b0, 10'd0, 10'd10);
        @(posedge clk_12_5875);
        @(posedge clk_12_5875);
        finish_req = 1;
        for (int i = 0; i < 10 && !final_done; i++) @(posedge clk_12_5875);
        if (!final_done) begin
            $display("FAIL drain got monitor_stalled exp done");
            $fatal(1, "monitor did not complete");
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
